// File: rtl/exec_stage_pkg.sv
// Shared micro-op definitions for the execute stage: op codes, FSM states,
// flag bit positions and the decoded micro-op record.
package exec_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_SAR = 4'd7,
        ALU_MOV = 4'd8,
        ALU_MUL = 4'd9,
        ALU_DIV = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        EX_IDLE,
        EX_MUL,
        EX_DIV,
        EX_HOLD
    } ex_state_t;

    // ex_flags layout is {OF,SF,ZF,CF}
    localparam int unsigned FLAG_CF = 0;
    localparam int unsigned FLAG_ZF = 1;
    localparam int unsigned FLAG_SF = 2;
    localparam int unsigned FLAG_OF = 3;

    localparam int unsigned MD_ITERS = 64;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [4:0]  rd;
        logic [7:0]  tag;
    } micro_op_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// acc holds {hi,lo} for MUL and {remainder,quotient} for DIV.
module ex_muldiv
    import exec_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [63:0]  opa,
    input  logic [63:0]  opb,
    output logic         done,
    output logic [127:0] result
);

    logic [127:0] acc;
    logic [127:0] acc_nxt;
    logic [63:0]  opnd;
    logic         div_mode;
    logic         busy;
    logic [6:0]   cnt;
    logic [64:0]  mul_sum;
    logic [64:0]  div_shl;
    logic [64:0]  div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opnd} : 65'd0);
        div_shl  = {acc[127:64], acc[63]};
        div_diff = div_shl - {1'b0, opnd};
        if (div_mode) begin
            // no borrow means the trial subtraction succeeds and a 1 enters the quotient
            if (!div_diff[64]) acc_nxt = {div_diff[63:0], acc[62:0], 1'b1};
            else               acc_nxt = {div_shl[63:0],  acc[62:0], 1'b0};
        end else begin
            acc_nxt = {mul_sum, acc[63:1]};
        end
    end

    assign done   = busy && (cnt == 7'(MD_ITERS - 1));
    assign result = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            acc      <= {64'd0, opa};
            opnd     <= opb;
            div_mode <= is_div;
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + 7'd1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU, multicycle MUL/DIV via ex_muldiv,
// result registers and back-pressure toward decode.
module exec_stage
    import exec_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  micro_op_t    uop,
    input  logic [63:0]  oprd1_val,
    input  logic [63:0]  oprd2_val,
    input  logic         mem_blocked,
    output logic         ex_blocked,
    output logic         ex_valid,
    output micro_op_t    ex_uop,
    output logic [127:0] alu_result,
    output logic [3:0]   ex_flags,
    output logic         div_err
);

    ex_state_t    state;
    ex_state_t    state_nxt;
    logic         accept;
    logic         is_mul;
    logic         is_div;
    logic         div_zero;
    logic         md_start;
    logic         md_done;
    logic [127:0] md_result;

    logic [63:0]  alu_res;
    logic [3:0]   flags_nxt;
    logic         flags_we;
    logic         cf;
    logic         of;
    logic [5:0]   shamt;
    logic [64:0]  sum;
    logic [64:0]  diff;
    logic [64:0]  shl;
    logic [64:0]  shr;
    logic [64:0]  sar;

    assign ex_blocked = (state != EX_IDLE) || (ex_valid && mem_blocked);
    assign accept     = enable && !ex_blocked;
    assign is_mul     = (uop.alu_op == ALU_MUL);
    assign is_div     = (uop.alu_op == ALU_DIV);
    assign div_zero   = is_div && (oprd2_val == 64'd0);
    assign md_start   = accept && (is_mul || (is_div && !div_zero));

    ex_muldiv u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (is_div),
        .opa    (oprd1_val),
        .opb    (oprd2_val),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        alu_res  = oprd2_val;
        flags_we = 1'b0;
        cf       = 1'b0;
        of       = 1'b0;
        shamt    = oprd2_val[5:0];
        sum      = {1'b0, oprd1_val} + {1'b0, oprd2_val};
        diff     = {1'b0, oprd1_val} - {1'b0, oprd2_val};
        // one guard bit on the shifted-out side captures the last bit lost as CF
        shl      = {1'b0, oprd1_val} << shamt;
        shr      = {oprd1_val, 1'b0} >> shamt;
        sar      = $signed({oprd1_val, 1'b0}) >>> shamt;
        case (uop.alu_op)
            ALU_ADD: begin
                alu_res  = sum[63:0];
                cf       = sum[64];
                of       = (oprd1_val[63] == oprd2_val[63]) && (alu_res[63] != oprd1_val[63]);
                flags_we = 1'b1;
            end
            ALU_SUB: begin
                alu_res  = diff[63:0];
                cf       = diff[64];
                of       = (oprd1_val[63] != oprd2_val[63]) && (alu_res[63] != oprd1_val[63]);
                flags_we = 1'b1;
            end
            ALU_AND: begin alu_res = oprd1_val & oprd2_val; flags_we = 1'b1; end
            ALU_OR:  begin alu_res = oprd1_val | oprd2_val; flags_we = 1'b1; end
            ALU_XOR: begin alu_res = oprd1_val ^ oprd2_val; flags_we = 1'b1; end
            ALU_SHL: begin alu_res = shl[63:0]; cf = shl[64]; flags_we = (shamt != 6'd0); end
            ALU_SHR: begin alu_res = shr[64:1]; cf = shr[0];  flags_we = (shamt != 6'd0); end
            ALU_SAR: begin alu_res = sar[64:1]; cf = sar[0];  flags_we = (shamt != 6'd0); end
            default: alu_res = oprd2_val;
        endcase
        flags_nxt          = '0;
        flags_nxt[FLAG_CF] = cf;
        flags_nxt[FLAG_ZF] = (alu_res == 64'd0);
        flags_nxt[FLAG_SF] = alu_res[63];
        flags_nxt[FLAG_OF] = of;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EX_IDLE: begin
                if (ex_valid && mem_blocked) state_nxt = EX_HOLD;
                else if (md_start)           state_nxt = is_mul ? EX_MUL : EX_DIV;
            end
            EX_MUL, EX_DIV: if (md_done) state_nxt = EX_IDLE;
            EX_HOLD:        if (!mem_blocked) state_nxt = EX_IDLE;
            default:        state_nxt = EX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EX_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_uop     <= '0;
            alu_result <= '0;
            ex_flags   <= '0;
            div_err    <= 1'b0;
        end else begin
            case (state)
                EX_IDLE: begin
                    if (accept) begin
                        ex_uop <= uop;
                        if (md_start) begin
                            ex_valid <= 1'b0;
                        end else if (div_zero) begin
                            alu_result <= {oprd1_val, {64{1'b1}}};
                            div_err    <= 1'b1;
                            ex_valid   <= 1'b1;
                        end else begin
                            alu_result <= {64'd0, alu_res};
                            div_err    <= 1'b0;
                            ex_valid   <= 1'b1;
                            if (flags_we) ex_flags <= flags_nxt;
                        end
                    end else if (!ex_blocked) begin
                        ex_valid <= 1'b0;
                    end
                end
                EX_MUL, EX_DIV: begin
                    if (md_done) begin
                        alu_result <= md_result;
                        div_err    <= 1'b0;
                        ex_valid   <= 1'b1;
                    end
                end
                EX_HOLD: if (!mem_blocked) ex_valid <= 1'b0;
                default: ex_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have `clk` as input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have `rst_n` as input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have `enable` as input, 1 bit: upstream presents a valid uop this cycle.
REQ-004 The block SHALL have `uop` as input, micro_op_t: decoded micro-op; its `alu_op` field is of type alu_op_t.
REQ-005 The block SHALL have `oprd1_val` as input, 64 bits: first source value.
REQ-006 The block SHALL have `oprd2_val` as input, 64 bits: second source value.
REQ-007 The block SHALL have `mem_blocked` as input, 1 bit: the downstream memory stage cannot take a new result.
REQ-008 The block SHALL have `ex_blocked` as output, 1 bit: stall upstream; `enable` is ignored while it is high.
REQ-009 The block SHALL have `ex_valid` as output, 1 bit: result valid; this drives the memory stage `enable`.
REQ-010 The block SHALL have `ex_uop` as output, micro_op_t: registered copy of the accepted uop.
REQ-011 The block SHALL have `alu_result` as output, 128 bits: registered result.
REQ-012 The block SHALL have `ex_flags` as output, 4 bits: {OF,SF,ZF,CF} of the last flag-setting op.
REQ-013 The block SHALL have `div_err` as output, 1 bit: high with `ex_valid` when the accepted DIV had a zero divisor.

Function
REQ-014 A uop SHALL be accepted in a cycle with `enable` high and `ex_blocked` low.
REQ-015 The state machine SHALL have the states EX_IDLE, EX_MUL, EX_DIV and EX_HOLD.
REQ-016 Single-cycle ops SHALL be ADD, SUB, AND, OR, XOR, SHL, SHR, SAR and MOV.
REQ-017 For a single-cycle op accepted at cycle N, the result SHALL be registered and `ex_valid` SHALL be high at N+1.
REQ-018 MUL SHALL be an unsigned 64x64 to 128 shift-add, one bit per cycle.
REQ-019 DIV SHALL be an unsigned 64/64 restoring divide, one bit per cycle, with quotient in [63:0] and remainder in [127:64].
REQ-020 For MUL or DIV accepted at cycle N, `ex_valid` SHALL rise at N+65, driven by a 7-bit iteration counter.
REQ-021 During MUL and DIV iterations, `ex_blocked` SHALL be 1 and `ex_valid` SHALL be 0.
REQ-022 DIV with `oprd2_val` equal to 0 SHALL skip iteration and complete at N+1 with quotient all-ones, remainder equal to `oprd1_val`, and `div_err` high.
REQ-023 For single-cycle ops, `alu_result[127:64]` SHALL be 0.
REQ-024 Shift counts SHALL be `oprd2_val[5:0]`; a count of 0 SHALL leave `ex_flags` unchanged.
REQ-025 ADD, SUB and the logical ops SHALL update `ex_flags`; CF and OF SHALL be 0 for the logical ops.
REQ-026 MOV and MUL SHALL leave `ex_flags` unchanged; DIV SHALL leave `ex_flags` unchanged.
REQ-027 `ex_valid` SHALL be a one-cycle pulse per result unless held by REQ-028.
REQ-028 If `ex_valid` is high and `mem_blocked` is high, the block SHALL enter EX_HOLD and hold `ex_valid`, `ex_uop`, `alu_result` and `div_err` stable.
REQ-029 In EX_HOLD, `ex_blocked` SHALL be 1; the block SHALL leave EX_HOLD in the first cycle `mem_blocked` is low, dropping `ex_valid` the next cycle.
REQ-030 `ex_blocked` SHALL be combinational: high in EX_MUL, EX_DIV or EX_HOLD, or when `ex_valid` and `mem_blocked` are both high.
REQ-031 When `enable` is low and the block is idle, `ex_valid` SHALL be 0 next cycle and the other outputs SHALL retain their values.
REQ-032 A uop with an undefined `alu_op` SHALL behave as MOV of `oprd2_val`.

Reset
REQ-033 When `rst_n` is sampled 0, the state SHALL become EX_IDLE and `ex_valid`, `div_err`, `ex_flags`, `alu_result`, `ex_uop` and the counter SHALL become 0.
REQ-034 Reset mid-MUL, mid-DIV or in EX_HOLD SHALL abort the operation with no result pulse.
REQ-035 `ex_blocked` SHALL be 0 in the first cycle after `rst_n` rises.

Structure
REQ-036 alu_op_t, ex_state_t and the flag bit indices SHALL live in the shared micro-op package/header next to micro_op_t.
REQ-037 The iterative multiply/divide datapath, with its counter, accumulator and start/done handshake, SHALL be a sub-module named ex_muldiv.
REQ-038 The exec_stage top SHALL contain the single-cycle ALU, the FSM, the output registers and the stall logic.

Verification
REQ-039 The bench SHALL check: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> at N+1 `alu_result` = 0 and `ex_flags` = {OF0,SF0,ZF1,CF1}.
REQ-040 The bench SHALL check: MUL 0xFFFF_FFFF_FFFF_FFFF x 2 -> at N+65 `alu_result` = 0x1_FFFF_FFFF_FFFF_FFFE and `ex_blocked` high for cycles N+1..N+64.
REQ-041 The bench SHALL check: DIV 100/7 -> at N+65 [63:0] = 14 and [127:64] = 2; DIV 5/0 -> at N+1 `div_err` = 1, quotient all-ones, remainder 5.
REQ-042 The bench SHALL check: SUB result with `mem_blocked` held high for 3 cycles -> `ex_valid` and `alu_result` stable for 4 cycles, no new uop accepted, and `ex_valid` = 0 the cycle after release.
REQ-043 The bench SHALL check: `rst_n` low at cycle 30 of a DIV -> no `ex_valid` pulse, and a following ADD 2+3 gives 5 at N+1.
REQ-044 The bench SHALL check: SAR 0x8000_0000_0000_0000 by 0x41 -> count 1, result 0xC000_0000_0000_0000, SF = 1.
